// File: rtl/dma_burst_planner_pkg.sv
// Shared types, register map and burst-sizing rule for the multi-channel DMA burst planner.
package dma_pkg;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_READY = 2'd1,
        CH_BUSY  = 2'd2,
        CH_DESC  = 2'd3
    } ch_state_t;

    localparam logic [2:0] REG_SRC       = 3'd0;
    localparam logic [2:0] REG_DST       = 3'd1;
    localparam logic [2:0] REG_LEN       = 3'd2;
    localparam logic [2:0] REG_NEXT      = 3'd3;
    localparam logic [2:0] REG_EOC       = 3'd4;
    localparam logic [2:0] REG_DESC_ADDR = 3'd5;
    localparam logic [2:0] REG_GO        = 3'd6;

    // Widest supported fields; the top narrows them to its parameters.
    typedef struct packed {
        logic [15:0] ch;
        logic [63:0] src;
        logic [63:0] dst;
        logic [15:0] len;
    } burst_req_t;

    // Beats for the next burst: limited by what is left, the AXI maximum and
    // the distance of either address to its next boundary line.
    function automatic longint unsigned burst_beats(
        input longint unsigned src,
        input longint unsigned dst,
        input longint unsigned remaining,
        input longint unsigned max_beats,
        input longint unsigned boundary,
        input longint unsigned bpb
    );
        longint unsigned beats;
        longint unsigned room;
        beats = (remaining < max_beats) ? remaining : max_beats;
        room  = (boundary - (src % boundary)) / bpb;
        if (room < beats) beats = room;
        room  = (boundary - (dst % boundary)) / bpb;
        if (room < beats) beats = room;
        return beats;
    endfunction

endpackage

// File: rtl/dma_burst_planner_rr_arbiter.sv
// Round-robin arbiter that holds its choice until the request is accepted.
module dma_rr_arbiter #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CH_W   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] request,
    input  logic              accept,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] lock_idx;
    logic [CH_W-1:0] pick_idx;
    logic            locked;
    logic            pick_any;
    int unsigned     k;

    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        k        = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            k = (32'(ptr) + i) % NUM_CH;
            if (!pick_any && request[k]) begin
                pick_any = 1'b1;
                pick_idx = CH_W'(k);
            end
        end
        // A stalled request keeps its channel even if a higher-priority one appears.
        grant_idx = locked ? lock_idx : pick_idx;
        grant     = '0;
        if (locked || pick_any) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr      <= '0;
            lock_idx <= '0;
            locked   <= 1'b0;
        end else if (accept) begin
            locked <= 1'b0;
            ptr    <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end else if (|grant) begin
            locked   <= 1'b1;
            lock_idx <= grant_idx;
        end
    end

endmodule

// File: rtl/dma_burst_planner.sv
// Per-channel descriptor sequencer: cuts descriptors into boundary-safe AXI bursts.
module dma_burst_planner
    import dma_pkg::*;
#(
    parameter  int unsigned NUM_CH   = 2,
    parameter  int unsigned ADDR_W   = 32,
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned LEN_W    = 4,
    parameter  int unsigned BOUNDARY = 4096,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_valid,
    input  logic [NUM_CH-1:0]        en,
    input  logic                     wen,
    input  logic [CH_W-1:0]          wch,
    input  logic [2:0]               waddr,
    input  logic [DATA_W-1:0]        wdata,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic [CH_W-1:0]          req_ch,
    output logic [ADDR_W-1:0]        req_src,
    output logic [ADDR_W-1:0]        req_dst,
    output logic [LEN_W-1:0]         req_len,
    input  logic                     burst_done,
    input  logic [CH_W-1:0]          done_ch,
    output logic [NUM_CH-1:0]        desc_valid,
    output logic [NUM_CH*ADDR_W-1:0] desc_addr,
    output logic [NUM_CH-1:0]        block_done,
    output logic [NUM_CH-1:0]        irq
);

    localparam int unsigned BPB       = DATA_W / 8;
    localparam int unsigned MAX_BEATS = 2 ** LEN_W;
    localparam int unsigned BW        = LEN_W + 1;

    ch_state_t         state   [NUM_CH];
    logic [ADDR_W-1:0] src_q   [NUM_CH];
    logic [ADDR_W-1:0] dst_q   [NUM_CH];
    logic [ADDR_W-1:0] next_q  [NUM_CH];
    logic [ADDR_W-1:0] daddr_q [NUM_CH];
    logic [DATA_W-1:0] rem_q   [NUM_CH];
    logic [BW-1:0]     beats_q [NUM_CH];
    logic [BW-1:0]     beats_c [NUM_CH];
    logic [NUM_CH-1:0] eoc_q;
    logic [NUM_CH-1:0] ready_vec, grant, wr_hit, go_hit, done_hit, finishing;
    logic [CH_W-1:0]   grant_idx;
    logic              accept;
    burst_req_t        req;

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ready_vec[c] = (state[c] == CH_READY);
            wr_hit[c]    = wen && (wch == CH_W'(c)) &&
                           (state[c] == CH_IDLE || state[c] == CH_DESC);
            go_hit[c]    = wr_hit[c] && (waddr == REG_GO);
            done_hit[c]  = burst_done && (done_ch == CH_W'(c)) && (state[c] == CH_BUSY);
            beats_c[c]   = BW'(burst_beats(64'(src_q[c]), 64'(dst_q[c]), 64'(rem_q[c]),
                                           64'(MAX_BEATS), 64'(BOUNDARY), 64'(BPB)));
            finishing[c] = (go_hit[c] && rem_q[c] == '0) ||
                           (done_hit[c] && rem_q[c] == DATA_W'(beats_q[c]));
            desc_addr[c*ADDR_W +: ADDR_W] = daddr_q[c];
        end
    end

    dma_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .request   (ready_vec),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_valid = |grant;
    assign accept    = req_valid && req_ready;

    always_comb begin
        req = '0;
        if (req_valid) begin
            req.ch  = 16'(grant_idx);
            req.src = 64'(src_q[grant_idx]);
            req.dst = 64'(dst_q[grant_idx]);
            req.len = 16'(beats_c[grant_idx] - BW'(1));
        end
    end

    assign req_ch  = CH_W'(req.ch);
    assign req_src = ADDR_W'(req.src);
    assign req_dst = ADDR_W'(req.dst);
    assign req_len = LEN_W'(req.len);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state[c]   <= CH_IDLE;
                src_q[c]   <= '0;
                dst_q[c]   <= '0;
                next_q[c]  <= '0;
                daddr_q[c] <= '0;
                rem_q[c]   <= '0;
                beats_q[c] <= '0;
            end
            eoc_q      <= '0;
            desc_valid <= '0;
            block_done <= '0;
            irq        <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                block_done[c] <= 1'b0;
                case (state[c])
                    CH_IDLE, CH_DESC: begin
                        if (wr_hit[c]) begin
                            case (waddr)
                                REG_SRC:       src_q[c]   <= ADDR_W'(wdata) & ~ADDR_W'(BPB - 1);
                                REG_DST:       dst_q[c]   <= ADDR_W'(wdata) & ~ADDR_W'(BPB - 1);
                                REG_LEN:       rem_q[c]   <= wdata;
                                REG_NEXT:      next_q[c]  <= ADDR_W'(wdata);
                                REG_EOC:       eoc_q[c]   <= wdata[0];
                                REG_DESC_ADDR: daddr_q[c] <= ADDR_W'(wdata);
                                REG_GO: begin
                                    desc_valid[c] <= 1'b0;
                                    state[c]      <= CH_READY;
                                end
                                default: ;
                            endcase
                        end
                    end
                    CH_READY: begin
                        if (grant[c] && accept) begin
                            beats_q[c] <= beats_c[c];
                            state[c]   <= CH_BUSY;
                        end
                    end
                    CH_BUSY: begin
                        if (done_hit[c]) begin
                            src_q[c] <= src_q[c] + ADDR_W'(beats_q[c]) * ADDR_W'(BPB);
                            dst_q[c] <= dst_q[c] + ADDR_W'(beats_q[c]) * ADDR_W'(BPB);
                            rem_q[c] <= rem_q[c] - DATA_W'(beats_q[c]);
                            state[c] <= CH_READY;
                        end
                    end
                    default: ;
                endcase
                // Descriptor completion overrides the READY transitions chosen above.
                if (finishing[c]) begin
                    block_done[c] <= 1'b1;
                    daddr_q[c]    <= next_q[c];
                    if (eoc_q[c]) begin
                        state[c] <= CH_IDLE;
                    end else begin
                        state[c]      <= CH_DESC;
                        desc_valid[c] <= 1'b1;
                    end
                end
                if (en_valid && !en[c]) irq[c] <= 1'b0;
                else if (finishing[c] && eoc_q[c]) irq[c] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_burst_planner.sv
// Randomised and directed checks of dma_burst_planner against a behavioural channel model.
module tb_dma_burst_planner;

    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned LEN_W    = 4;
    localparam int unsigned BOUNDARY = 4096;
    localparam int unsigned CH_W     = 1;
    localparam int unsigned BPB      = 4;
    localparam int unsigned MAXB     = 16;

    localparam int PH_IDLE = 0, PH_READY = 1, PH_BUSY = 2, PH_DESC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, en_valid, wen, req_ready, burst_done;
    logic [NUM_CH-1:0]        en;
    logic [CH_W-1:0]          wch, done_ch;
    logic [2:0]               waddr;
    logic [DATA_W-1:0]        wdata;
    logic                     req_valid;
    logic [CH_W-1:0]          req_ch;
    logic [ADDR_W-1:0]        req_src, req_dst;
    logic [LEN_W-1:0]         req_len;
    logic [NUM_CH-1:0]        desc_valid, block_done, irq;
    logic [NUM_CH*ADDR_W-1:0] desc_addr;

    dma_burst_planner #(
        .NUM_CH   (NUM_CH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LEN_W    (LEN_W),
        .BOUNDARY (BOUNDARY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_valid   (en_valid),
        .en         (en),
        .wen        (wen),
        .wch        (wch),
        .waddr      (waddr),
        .wdata      (wdata),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ch     (req_ch),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .req_len    (req_len),
        .burst_done (burst_done),
        .done_ch    (done_ch),
        .desc_valid (desc_valid),
        .desc_addr  (desc_addr),
        .block_done (block_done),
        .irq        (irq)
    );

    // Behavioural model of every channel
    int          m_phase [NUM_CH];
    bit [31:0]   m_src [NUM_CH], m_dst [NUM_CH], m_rem [NUM_CH], m_next [NUM_CH], m_daddr [NUM_CH];
    bit          m_eoc [NUM_CH];
    int          m_beats [NUM_CH];
    bit [NUM_CH-1:0] m_dv, m_bd, m_irq;
    int          m_ptr, m_lock_ch;
    bit          m_locked;

    bit          p_valid;
    int          p_ch, p_len;
    bit [31:0]   p_src, p_dst;

    int n_vec = 0, n_err = 0;
    int bd_cnt [NUM_CH];
    bit auto_resp = 1'b0, rand_mode = 1'b0;

    typedef struct {
        int          ch;
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
    } rec_t;
    rec_t log_q[$];

    function automatic int beats_for(bit [31:0] s, bit [31:0] d, bit [31:0] r);
        bit [31:0] b;
        b = (r > MAXB) ? MAXB : r;
        if ((BOUNDARY - s % BOUNDARY) / BPB < b) b = (BOUNDARY - s % BOUNDARY) / BPB;
        if ((BOUNDARY - d % BOUNDARY) / BPB < b) b = (BOUNDARY - d % BOUNDARY) / BPB;
        return int'(b);
    endfunction

    function automatic void predict();
        p_valid = 1'b0;
        p_ch    = 0;
        if (m_locked) begin
            p_valid = 1'b1;
            p_ch    = m_lock_ch;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                int k;
                k = (m_ptr + i) % NUM_CH;
                if (!p_valid && m_phase[k] == PH_READY) begin
                    p_valid = 1'b1;
                    p_ch    = k;
                end
            end
        end
        p_src = m_src[p_ch];
        p_dst = m_dst[p_ch];
        p_len = beats_for(m_src[p_ch], m_dst[p_ch], m_rem[p_ch]) - 1;
    endfunction

    function automatic void model_update();
        int  pre [NUM_CH];
        bit  fin;
        bit  hs;
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_phase[c] = PH_IDLE; m_src[c] = 0; m_dst[c] = 0; m_rem[c] = 0;
                m_next[c] = 0; m_daddr[c] = 0; m_eoc[c] = 0; m_beats[c] = 0;
            end
            m_dv = '0; m_bd = '0; m_irq = '0; m_ptr = 0; m_locked = 0; m_lock_ch = 0;
            return;
        end
        predict();
        hs = p_valid && req_ready;
        for (int c = 0; c < NUM_CH; c++) pre[c] = m_phase[c];
        m_bd = '0;
        if (hs) begin
            m_phase[p_ch] = PH_BUSY;
            m_beats[p_ch] = p_len + 1;
            m_ptr         = (p_ch + 1) % NUM_CH;
            m_locked      = 1'b0;
        end else if (p_valid) begin
            m_locked  = 1'b1;
            m_lock_ch = p_ch;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            fin = 1'b0;
            if ((pre[c] == PH_IDLE || pre[c] == PH_DESC) && wen && int'(wch) == c) begin
                case (int'(waddr))
                    0: m_src[c]   = wdata & ~32'(BPB - 1);
                    1: m_dst[c]   = wdata & ~32'(BPB - 1);
                    2: m_rem[c]   = wdata;
                    3: m_next[c]  = wdata;
                    4: m_eoc[c]   = wdata[0];
                    5: m_daddr[c] = wdata;
                    6: begin
                        m_dv[c] = 1'b0;
                        if (m_rem[c] != 0) m_phase[c] = PH_READY;
                        else fin = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (pre[c] == PH_BUSY && burst_done && int'(done_ch) == c) begin
                m_src[c] = m_src[c] + 32'(m_beats[c] * BPB);
                m_dst[c] = m_dst[c] + 32'(m_beats[c] * BPB);
                m_rem[c] = m_rem[c] - 32'(m_beats[c]);
                if (m_rem[c] != 0) m_phase[c] = PH_READY;
                else fin = 1'b1;
            end
            if (fin) begin
                m_bd[c]    = 1'b1;
                m_daddr[c] = m_next[c];
                if (m_eoc[c]) begin
                    m_irq[c]   = 1'b1;
                    m_phase[c] = PH_IDLE;
                end else begin
                    m_dv[c]    = 1'b1;
                    m_phase[c] = PH_DESC;
                end
            end
            if (en_valid && !en[c]) m_irq[c] = 1'b0;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("req_valid", 64'(req_valid), 64'(p_valid));
        if (p_valid) begin
            chk("req_ch",  64'(req_ch),  64'(p_ch));
            chk("req_src", 64'(req_src), 64'(p_src));
            chk("req_dst", 64'(req_dst), 64'(p_dst));
            chk("req_len", 64'(req_len), 64'(p_len));
        end
        chk("block_done", 64'(block_done), 64'(m_bd));
        chk("irq",        64'(irq),        64'(m_irq));
        chk("desc_valid", 64'(desc_valid), 64'(m_dv));
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("desc_addr%0d", c), 64'(desc_addr[c*ADDR_W +: ADDR_W]), 64'(m_daddr[c]));
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge after checking.
    task automatic tick();
        int busy[$];
        rec_t r;
        if (auto_resp) begin
            busy.delete();
            for (int c = 0; c < NUM_CH; c++) if (m_phase[c] == PH_BUSY) busy.push_back(c);
            if (busy.size() > 0 && (!rand_mode || $urandom_range(0, 2) == 0)) begin
                burst_done = 1'b1;
                done_ch    = rand_mode ? CH_W'(busy[$urandom_range(0, busy.size() - 1)]) : CH_W'(busy[0]);
            end else if (rand_mode && $urandom_range(0, 15) == 0) begin
                burst_done = 1'b1;
                done_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
            end else begin
                burst_done = 1'b0;
            end
        end
        #1;
        if (req_valid === 1'b1 && req_ready === 1'b1) begin
            r.ch = int'(req_ch); r.src = req_src; r.dst = req_dst; r.len = int'(req_len);
            log_q.push_back(r);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        predict();
        compare_all();
        for (int c = 0; c < NUM_CH; c++) if (block_done[c] === 1'b1) bd_cnt[c]++;
    endtask

    task automatic wr(input int ch, input int a, input logic [31:0] d);
        wen = 1'b1; wch = CH_W'(ch); waddr = 3'(a); wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic wait_phase(input int ch, input int ph, input int budget);
        int n;
        n = 0;
        while (m_phase[ch] != ph && n < budget) begin
            tick();
            n++;
        end
        n_vec++;
        if (m_phase[ch] != ph) begin
            n_err++;
            $display("FAIL wait_phase ch%0d: phase %0d after %0d cycles, required %0d", ch, m_phase[ch], n, ph);
        end
    endtask

    task automatic clear_irq();
        en_valid = 1'b1; en = '0;
        tick();
        en_valid = 1'b0; en = '1;
    endtask

    task automatic check_log(input string nm, input int idx, input int ch, input logic [31:0] s,
                             input logic [31:0] d, input int len);
        n_vec++;
        if (idx >= log_q.size()) begin
            n_err++;
            $display("FAIL %s: only %0d requests logged, required entry %0d", nm, log_q.size(), idx);
        end else begin
            n_vec--;
            chk({nm, "_ch"},  64'(log_q[idx].ch),  64'(ch));
            chk({nm, "_src"}, 64'(log_q[idx].src), 64'(s));
            chk({nm, "_dst"}, 64'(log_q[idx].dst), 64'(d));
            chk({nm, "_len"}, 64'(log_q[idx].len), 64'(len));
        end
    endtask

    initial begin
        logic [31:0] rv;
        int          ra;
        rst = 1'b0; en_valid = 1'b0; en = '1; wen = 1'b0; wch = '0; waddr = '0; wdata = '0;
        req_ready = 1'b0; burst_done = 1'b0; done_ch = '0;
        for (int c = 0; c < NUM_CH; c++) bd_cnt[c] = 0;
        model_update();
        @(negedge clk);
        tick();
        tick();
        chk("reset_req_valid",  64'(req_valid),  64'd0);
        chk("reset_irq",        64'(irq),        64'd0);
        chk("reset_desc_valid", 64'(desc_valid), 64'd0);
        chk("reset_desc_addr",  64'(desc_addr),  64'd0);
        rst = 1'b1;
        tick();

        // 40 beats from 0x1000: 16 + 16 + 8
        req_ready = 1'b1; auto_resp = 1'b1; log_q.delete(); bd_cnt[0] = 0;
        wr(0, 0, 32'h1000); wr(0, 1, 32'h2000); wr(0, 2, 40); wr(0, 4, 1);
        wr(0, 6, 0);
        chk("go_then_req_valid", 64'(req_valid), 64'd1);
        wait_phase(0, PH_IDLE, 60);
        check_log("s1_b0", 0, 0, 32'h1000, 32'h2000, 15);
        check_log("s1_b1", 1, 0, 32'h1040, 32'h2040, 15);
        check_log("s1_b2", 2, 0, 32'h1080, 32'h2080, 7);
        chk("s1_block_done_pulses", 64'(bd_cnt[0]), 64'd1);
        chk("s1_irq", 64'(irq[0]), 64'd1);
        clear_irq();

        // Boundary split at 0x2000
        log_q.delete();
        wr(0, 0, 32'h1FF0); wr(0, 1, 32'h3000); wr(0, 2, 16); wr(0, 6, 0);
        wait_phase(0, PH_IDLE, 60);
        check_log("s2_b0", 0, 0, 32'h1FF0, 32'h3000, 3);
        check_log("s2_b1", 1, 0, 32'h2000, 32'h3010, 11);
        clear_irq();

        // Two channels interleave
        log_q.delete(); req_ready = 1'b0;
        wr(0, 0, 32'h0);     wr(0, 1, 32'h10000); wr(0, 2, 32); wr(0, 4, 1);
        wr(1, 0, 32'h20000); wr(1, 1, 32'h30000); wr(1, 2, 32); wr(1, 4, 1);
        wr(0, 6, 0); wr(1, 6, 0);
        req_ready = 1'b1;
        wait_phase(0, PH_IDLE, 60);
        wait_phase(1, PH_IDLE, 60);
        check_log("s3_g0", 0, 0, 32'h0,     32'h10000, 15);
        check_log("s3_g1", 1, 1, 32'h20000, 32'h30000, 15);
        check_log("s3_g2", 2, 0, 32'h40,    32'h10040, 15);
        check_log("s3_g3", 3, 1, 32'h20040, 32'h30040, 15);
        clear_irq();

        // Linked descriptor
        wr(0, 0, 32'h4000); wr(0, 1, 32'h5000); wr(0, 2, 4); wr(0, 4, 0); wr(0, 3, 32'h8000);
        wr(0, 6, 0);
        wait_phase(0, PH_DESC, 30);
        chk("s4_desc_valid", 64'(desc_valid[0]), 64'd1);
        chk("s4_desc_addr",  64'(desc_addr[31:0]), 64'h8000);
        chk("s4_irq",        64'(irq[0]), 64'd0);
        wr(0, 2, 4); wr(0, 4, 1);
        chk("s4_desc_valid_held", 64'(desc_valid[0]), 64'd1);
        wr(0, 6, 0);
        chk("s4_desc_valid_drop", 64'(desc_valid[0]), 64'd0);
        wait_phase(0, PH_IDLE, 30);
        clear_irq();

        // Zero-length GO, then clear winning over set
        auto_resp = 1'b0;
        wr(1, 2, 0); wr(1, 4, 1);
        wr(1, 6, 0);
        chk("s5_no_req",     64'(req_valid),     64'd0);
        chk("s5_block_done", 64'(block_done[1]), 64'd1);
        chk("s5_irq_set",    64'(irq[1]),        64'd1);
        clear_irq();
        en_valid = 1'b1; en = 2'b01;
        wr(1, 6, 0);
        en_valid = 1'b0; en = '1;
        chk("s5_irq_clear_wins", 64'(irq[1]),        64'd0);
        chk("s5_block_done2",    64'(block_done[1]), 64'd1);

        // Stall holds the request, then reset mid-burst
        req_ready = 1'b0;
        wr(0, 0, 32'h6000); wr(0, 1, 32'h7000); wr(0, 2, 8); wr(0, 6, 0);
        wr(1, 0, 32'h9000); wr(1, 1, 32'hA000); wr(1, 2, 8); wr(1, 6, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s6_stall_valid", 64'(req_valid), 64'd1);
            chk("s6_stall_ch",    64'(req_ch),    64'd0);
            chk("s6_stall_src",   64'(req_src),   64'h6000);
            chk("s6_stall_len",   64'(req_len),   64'd7);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("s6_rst_req_valid",  64'(req_valid),  64'd0);
        chk("s6_rst_desc_addr",  64'(desc_addr),  64'd0);
        chk("s6_rst_block_done", 64'(block_done), 64'd0);
        burst_done = 1'b1; done_ch = '0;
        tick();
        burst_done = 1'b0;
        chk("s6_late_done_bd",    64'(block_done), 64'd0);
        chk("s6_late_done_valid", 64'(req_valid),  64'd0);

        // Random traffic
        auto_resp = 1'b1; rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            req_ready = ($urandom_range(0, 3) != 0);
            en_valid  = ($urandom_range(0, 31) == 0);
            en        = NUM_CH'($urandom);
            rst       = ($urandom_range(0, 599) != 0);
            wen       = ($urandom_range(0, 2) == 0);
            wch       = CH_W'($urandom_range(0, NUM_CH - 1));
            ra        = ($urandom_range(0, 9) < 3) ? 6 : $urandom_range(0, 7);
            waddr     = 3'(ra);
            rv        = $urandom;
            if (ra == 2) rv = $urandom_range(0, 40);
            else if ((ra == 0 || ra == 1) && $urandom_range(0, 1) == 0)
                rv = (rv & 32'hFFFF_F000) | 32'(BOUNDARY - $urandom_range(1, 80));
            wdata = rv;
            tick();
        end
        wen = 1'b0; rst = 1'b1; en_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
